scan_cfg_loader: RTL and testbench

- Configuration master for the fabric scan chains. Drives the `clb_scan_*` / `conn_scan_*` shift chains of the tile array from a 32-bit host word stream.
- Generates `scan_clk` and the per-chain scan enables, and shifts bits serially into the selected chain.
- Captures the bits shifted out of the chain tail and returns them as 32-bit readback words, so previous contents can be verified.
- Sits between the host/bitstream interface and the top-level fabric array.

---
 rtl/fpga_cfg_pkg.sv | 22 ++
 rtl/scan_clk_gen.sv | 40 ++++
 rtl/scan_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_scan_cfg_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpga_cfg_pkg: shared types and constants for the scan-chain config loader.
// rev 1.0
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

  localparam int   CFG_WORD_W = 32;
  localparam logic SEL_CLB    = 1'b0;
  localparam logic SEL_CONN   = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SH_LO = 3'd2,
    SH_HI = 3'd3,
    RB    = 3'd4,
    FIN   = 3'd5
  } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_clk_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_clk_gen: HALF-cycle phase counter driving a flop-based scan clock.
// rev 1.0
// ---------------------------------------------------------------------------
module scan_clk_gen #(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic scan_clk,
  output logic phase_end
);

  localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  // Counter and the FSM enter a shift phase on the same edge, so they stay in lockstep.
  assign phase_end = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      scan_clk <= 1'b0;
    end else if (!run) begin
      cnt      <= '0;
      scan_clk <= 1'b0;
    end else if (phase_end) begin
      cnt      <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      cnt      <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/scan_cfg_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_cfg_loader: loads 32-bit host words serially into the CLB/CONN scan
// chains and returns the shifted-out bits as readback words.  rev 1.0
// ---------------------------------------------------------------------------
module scan_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CLB_LEN  = 512,
  parameter int CONN_LEN = 2048,
  parameter int HALF     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sel,
  output logic                  busy,
  output logic                  done,
  input  logic [CFG_WORD_W-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [CFG_WORD_W-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  scan_clk,
  output logic                  clb_scan_en,
  output logic                  conn_scan_en,
  output logic                  clb_scan_in,
  input  logic                  clb_scan_out,
  output logic                  conn_scan_in,
  input  logic                  conn_scan_out
);

  localparam int MAXLEN = (CLB_LEN > CONN_LEN) ? CLB_LEN : CONN_LEN;
  localparam int LW     = ($clog2(MAXLEN + 1) > 6) ? $clog2(MAXLEN + 1) : 6;

  cfg_state_t            state;
  logic                  sel_q;
  logic [LW-1:0]         len;
  logic [LW-1:0]         sent;
  logic [LW-1:0]         remaining;
  logic [5:0]            nbits;
  logic [5:0]            k;
  logic [CFG_WORD_W-2:0] sr;
  logic                  run;
  logic                  phase_end;
  logic                  tail;

  assign run       = (state == SH_LO) || (state == SH_HI);
  assign remaining = len - sent;
  assign tail      = (sel_q == SEL_CONN) ? conn_scan_out : clb_scan_out;

  scan_clk_gen #(.HALF(HALF)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .scan_clk  (scan_clk),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel_q        <= SEL_CLB;
      len          <= '0;
      sent         <= '0;
      nbits        <= '0;
      k            <= '0;
      sr           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_ready     <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_en <= 1'b0;
      clb_scan_in  <= 1'b0;
      conn_scan_in <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sel_q        <= sel;
          len          <= (sel == SEL_CONN) ? LW'(CONN_LEN) : LW'(CLB_LEN);
          sent         <= '0;
          busy         <= 1'b1;
          wr_ready     <= 1'b1;
          clb_scan_en  <= (sel == SEL_CLB);
          conn_scan_en <= (sel == SEL_CONN);
          state        <= LOAD;
        end
        LOAD: if (wr_valid) begin
          // Bit 0 goes straight to the pin; sr holds the bits still to come.
          sr           <= wr_data[CFG_WORD_W-1:1];
          clb_scan_in  <= (sel_q == SEL_CLB) && wr_data[0];
          conn_scan_in <= (sel_q == SEL_CONN) && wr_data[0];
          nbits        <= (remaining >= LW'(CFG_WORD_W)) ? 6'(CFG_WORD_W) : remaining[5:0];
          k            <= '0;
          rd_data      <= '0;
          wr_ready     <= 1'b0;
          state        <= SH_LO;
        end
        SH_LO: if (phase_end) begin
          rd_data[k[4:0]] <= tail;
          state           <= SH_HI;
        end
        SH_HI: if (phase_end) begin
          k            <= k + 6'd1;
          sent         <= sent + LW'(1);
          sr           <= sr >> 1;
          clb_scan_in  <= (sel_q == SEL_CLB) && sr[0];
          conn_scan_in <= (sel_q == SEL_CONN) && sr[0];
          if ((k + 6'd1) < nbits) begin
            state <= SH_LO;
          end else begin
            rd_valid <= 1'b1;
            state    <= RB;
          end
        end
        RB: if (rd_ready) begin
          rd_valid <= 1'b0;
          if (sent == len) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            clb_scan_en  <= 1'b0;
            conn_scan_en <= 1'b0;
            clb_scan_in  <= 1'b0;
            conn_scan_in <= 1'b0;
            state        <= FIN;
          end else begin
            wr_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_cfg_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scan_cfg_loader: scan-chain models plus a word-level reference for the loader.
// rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_cfg_loader;

  localparam int CLB_LEN  = 40;
  localparam int CONN_LEN = 8;
  localparam int HALF     = 2;
  localparam int TMO      = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic        busy, done, wr_ready, rd_valid, scan_clk;
  logic [31:0] rd_data;
  logic        clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in;
  logic        clb_scan_out, conn_scan_out;

  always #5 clk = ~clk;

  scan_cfg_loader #(.CLB_LEN(CLB_LEN), .CONN_LEN(CONN_LEN), .HALF(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .busy(busy), .done(done),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .scan_clk(scan_clk), .clb_scan_en(clb_scan_en), .conn_scan_en(conn_scan_en),
    .clb_scan_in(clb_scan_in), .clb_scan_out(clb_scan_out),
    .conn_scan_in(conn_scan_in), .conn_scan_out(conn_scan_out)
  );

  // Fabric chain models: tail is bit 0, head enters at the top on each rising scan_clk.
  logic [CLB_LEN-1:0]  clb_v = '0;
  logic [CONN_LEN-1:0] conn_v = '0;
  int clb_edges = 0, conn_edges = 0;
  assign clb_scan_out  = clb_v[0];
  assign conn_scan_out = conn_v[0];

  always @(posedge scan_clk) begin
    if (clb_scan_en) begin
      clb_v     <= {clb_scan_in, clb_v[CLB_LEN-1:1]};
      clb_edges <= clb_edges + 1;
    end
    if (conn_scan_en) begin
      conn_v     <= {conn_scan_in, conn_v[CONN_LEN-1:1]};
      conn_edges <= conn_edges + 1;
    end
  end

  int   excl_bad = 0, phase_bad = 0, run_len = 0;
  logic prev_sc = 1'b0;
  always @(negedge clk) begin
    if ((clb_scan_en && conn_scan_en) || (!clb_scan_en && clb_scan_in) ||
        (!conn_scan_en && conn_scan_in) || (scan_clk && !clb_scan_en && !conn_scan_en))
      excl_bad <= excl_bad + 1;
    prev_sc <= scan_clk;
    if (scan_clk != prev_sc) begin
      if ((prev_sc && run_len != HALF) || (!prev_sc && run_len < HALF))
        phase_bad <= phase_bad + 1;
      run_len <= 1;
    end else begin
      run_len <= run_len + 1;
    end
  end

  int total = 0, bad = 0;
  logic [63:0] ref_clb = '0, ref_conn = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lmask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic do_load(input logic s, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] erd0, input logic [31:0] erd1,
                         input logic [63:0] echain, input int rd_hold, input int wr_gap,
                         input bit flip, input string tag);
    int len, nw, nwr, nrd, cyc, holdc, gapc, dones, stall_bad, e0c, e0n, esel, eoth;
    bit flipped;
    logic [31:0] wq [2];
    logic [31:0] rq [2];
    logic [63:0] newv;
    len = s ? CONN_LEN : CLB_LEN;
    nw  = (len + 31) / 32;
    newv = {w1, w0} & lmask(len);
    wq[0] = w0; wq[1] = w1; rq[0] = 'x; rq[1] = 'x;
    nwr = 0; nrd = 0; cyc = 0; holdc = 0; gapc = 0; dones = 0; stall_bad = 0;
    flipped = 0; e0c = clb_edges; e0n = conn_edges;
    @(negedge clk); start = 1'b1; sel = s;
    @(negedge clk); start = 1'b0; sel = ~s;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    while (nrd < nw && cyc < TMO) begin
      start = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0; wr_data = $urandom;
      if ((wr_ready || rd_valid) && scan_clk) stall_bad++;
      if (wr_ready && nwr < nw) begin
        if (nwr == nw - 1 && gapc < wr_gap) gapc++;
        else begin wr_valid = 1'b1; wr_data = wq[nwr]; nwr++; end
      end
      if (rd_valid) begin
        if (holdc < rd_hold) holdc++;
        else begin rd_ready = 1'b1; rq[nrd] = rd_data; nrd++; holdc = 0; end
      end
      if (flip && nwr == 1 && !flipped && !wr_ready) begin
        start = 1'b1; sel = ~s; flipped = 1;
      end
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b0; wr_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    esel = s ? conn_edges - e0n : clb_edges - e0c;
    eoth = s ? clb_edges - e0c : conn_edges - e0n;
    chk({tag, " timeout"}, 64'(cyc < TMO), 64'd1);
    chk({tag, " rd0"}, 64'(rq[0]), 64'(erd0));
    if (nw > 1) chk({tag, " rd1"}, 64'(rq[1]), 64'(erd1));
    chk({tag, " chain"}, s ? 64'(conn_v) : 64'(clb_v), echain);
    chk({tag, " edges"}, 64'(esel), 64'(len));
    chk({tag, " other edges"}, 64'(eoth), 64'd0);
    chk({tag, " words in"}, 64'(nwr), 64'(nw));
    chk({tag, " done pulses"}, 64'(dones), 64'd1);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    chk({tag, " stall scan_clk"}, 64'(stall_bad), 64'd0);
    if (s) ref_conn = newv; else ref_clb = newv;
  endtask

  task automatic run_ref(input logic s, input logic [31:0] w0, input logic [31:0] w1,
                         input int rdh, input int gap, input bit flip, input string tag);
    logic [63:0] old;
    int len;
    len = s ? CONN_LEN : CLB_LEN;
    old = s ? ref_conn : ref_clb;
    do_load(s, w0, w1, old[31:0], old[63:32], {w1, w0} & lmask(len), rdh, gap, flip, tag);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] w0, w1, erd0, erd1;
    logic [63:0] echain;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int idle_bad, cyc, e0;
    logic [31:0] w0r;
    tbl[0] = '{1'b0, 32'h3456789A, 32'h00000012, 32'h0, 32'h0, 64'h12_3456789A};
    tbl[1] = '{1'b0, 32'hDEADBEEF, 32'h000000A5, 32'h3456789A, 32'h00000012, 64'hA5_DEADBEEF};
    tbl[2] = '{1'b1, 32'hFFFFFF3C, 32'h0, 32'h0, 32'h0, 64'h3C};
    tbl[3] = '{1'b1, 32'h12345681, 32'h0, 32'h0000003C, 32'h0, 64'h81};
    tbl[4] = '{1'b0, 32'hCAFEF00D, 32'hFFFFFF77, 32'hDEADBEEF, 32'h000000A5, 64'h77_CAFEF00D};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'({busy, done, wr_ready, rd_valid, rd_data, scan_clk, clb_scan_en,
                              conn_scan_en, clb_scan_in, conn_scan_in}), 64'd0);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (scan_clk || busy || wr_ready) idle_bad++;
    end
    chk("idle quiet", 64'(idle_bad), 64'd0);

    for (int i = 0; i < 5; i++)
      do_load(tbl[i].s, tbl[i].w0, tbl[i].w1, tbl[i].erd0, tbl[i].erd1, tbl[i].echain,
              0, 0, 0, $sformatf("vec%0d", i));

    run_ref(1'b0, 32'h0F0F0F0F, 32'h000000C3, 20, 15, 0, "stall clb");
    run_ref(1'b1, 32'h000000A6, 32'h0, 20, 15, 0, "stall conn");
    run_ref(1'b0, 32'h13579BDF, 32'h2468ACE0, 0, 0, 1, "flip clb");
    run_ref(1'b1, 32'h5A5A5A5A, 32'h0, 0, 0, 1, "flip conn");

    for (int i = 0; i < 8; i++)
      run_ref(1'($urandom % 2), $urandom, $urandom, int'($urandom % 4), int'($urandom % 4),
              1'($urandom % 2), $sformatf("rand%0d", i));

    // Abort a CLB load after 17 bits, then reload from scratch.
    @(negedge clk); start = 1'b1; sel = 1'b0;
    @(negedge clk); start = 1'b0;
    w0r = $urandom; cyc = 0; e0 = clb_edges;
    while (!wr_ready && cyc < 50) begin @(negedge clk); cyc++; end
    wr_valid = 1'b1; wr_data = w0r;
    @(negedge clk); wr_valid = 1'b0;
    while ((clb_edges - e0) < 17 && cyc < 500) begin @(negedge clk); cyc++; end
    while (scan_clk && cyc < 500) begin @(negedge clk); cyc++; end
    chk("mid reset reach", 64'(cyc < 500), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("mid reset outputs", 64'({busy, done, wr_ready, rd_valid, rd_data, scan_clk, clb_scan_en,
                                     conn_scan_en, clb_scan_in, conn_scan_in}), 64'd0);
    chk("mid reset edges", 64'(clb_edges - e0), 64'd17);
    ref_clb = ((ref_clb >> 17) | (64'(w0r[16:0]) << (CLB_LEN - 17))) & lmask(CLB_LEN);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_ref(1'b0, 32'hA1B2C3D4, 32'h000000E5, 0, 0, 0, "reload1");
    run_ref(1'b0, 32'h01234567, 32'h00000089, 1, 1, 0, "reload2");

    chk("enable exclusivity", 64'(excl_bad), 64'd0);
    chk("scan_clk phases", 64'(phase_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
